// File: rtl/read_data_dispatcher.sv
// read_data_dispatcher: routes in-order SRAM read returns to per-port holding registers via a tag FIFO.
module read_data_dispatcher #(
  parameter int num_of_ports = 16,
  parameter int arbiter_data_width = 256,
  parameter int tag_depth = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       issue_valid,
  input  logic [3:0]                                 issue_port,
  output logic                                       issue_ready,
  input  logic                                       rd_data_valid,
  input  logic [arbiter_data_width-1:0]              rd_data,
  output logic [arbiter_data_width*num_of_ports-1:0] port_data,
  output logic [num_of_ports-1:0]                    port_valid,
  input  logic [num_of_ports-1:0]                    port_ready,
  output logic [4:0]                                 outstanding,
  output logic                                       err_underflow
);
  localparam int aw = (tag_depth > 1) ? $clog2(tag_depth) : 1;
  logic [3:0] tags [tag_depth];
  logic [aw-1:0] wp, rp;
  logic [num_of_ports-1:0] busy, deliver, set_pv, set_busy;
  logic [15:0] busy_w;
  logic [3:0] head;
  logic full, empty, push, pop;
  // Port indices beyond num_of_ports read as busy so they can never be accepted.
  assign busy_w = ~16'(~busy);
  assign full = outstanding == 5'(tag_depth);
  assign empty = outstanding == 5'd0;
  assign issue_ready = !full && !busy_w[issue_port] && !rst;
  assign push = issue_valid && issue_ready;
  assign pop = rd_data_valid && !empty;
  assign head = tags[rp];
  assign deliver = port_valid & port_ready;
  assign set_pv = pop ? {{(num_of_ports-1){1'b0}}, 1'b1} << head : '0;
  assign set_busy = push ? {{(num_of_ports-1){1'b0}}, 1'b1} << issue_port : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      outstanding <= '0;
      busy <= '0;
      port_valid <= '0;
      port_data <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) begin
        tags[wp] <= issue_port;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
        port_data[int'(head)*arbiter_data_width +: arbiter_data_width] <= rd_data;
      end
      outstanding <= outstanding + {4'd0, push} - {4'd0, pop};
      busy <= (busy & ~deliver) | set_busy;
      port_valid <= (port_valid & ~deliver) | set_pv;
      err_underflow <= err_underflow | (rd_data_valid && empty);
    end
  end
endmodule

// File: tb/tb_read_data_dispatcher.sv
// tb_read_data_dispatcher: table-driven directed checks plus full-FIFO and mid-run reset sequences.
module tb_read_data_dispatcher;
  localparam int np = 16;
  localparam int dw = 256;
  logic clk = 1'b0;
  logic rst, issue_valid, issue_ready, rd_data_valid, err_underflow;
  logic [3:0] issue_port;
  logic [dw-1:0] rd_data;
  logic [dw*np-1:0] port_data;
  logic [np-1:0] port_valid, port_ready;
  logic [4:0] outstanding;
  int total = 0, bad = 0;

  read_data_dispatcher dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_port(issue_port),
    .issue_ready(issue_ready), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .port_data(port_data), .port_valid(port_valid), .port_ready(port_ready),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, iv;
    logic [3:0] ip;
    logic rdv;
    logic [7:0] rb;
    logic [15:0] pr;
    logic er;
    logic [4:0] eo;
    logic [15:0] epv;
    logic ee;
    logic [3:0] cp;
    logic [7:0] cb;
  } vec_t;
  vec_t v [21];

  task automatic chk(input string name, input logic [dw-1:0] act, input logic [dw-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] ip, input logic rdv,
                       input logic [7:0] rb, input logic [15:0] pr);
    rst = r;
    issue_valid = iv;
    issue_port = ip;
    rd_data_valid = rdv;
    rd_data = {32{rb}};
    port_ready = pr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        rst iv ip  rdv rb     pr        er eo  epv       ee cp     cb
    v[0]  = '{1, 0, 0,  0, 8'h00, 16'h0000, 0, 0, 16'h0000, 0, 4'd3, 8'h00};
    v[1]  = '{0, 1, 3,  0, 8'h00, 16'h0000, 1, 1, 16'h0000, 0, 4'd3, 8'h00};
    v[2]  = '{0, 0, 0,  1, 8'hA5, 16'h0000, 1, 0, 16'h0008, 0, 4'd3, 8'hA5};
    v[3]  = '{0, 0, 0,  0, 8'h00, 16'h0008, 1, 0, 16'h0000, 0, 4'd3, 8'hA5};
    v[4]  = '{0, 1, 5,  0, 8'h00, 16'h0000, 1, 1, 16'h0000, 0, 4'd5, 8'h00};
    v[5]  = '{0, 1, 2,  0, 8'h00, 16'h0000, 1, 2, 16'h0000, 0, 4'd2, 8'h00};
    v[6]  = '{0, 1, 9,  1, 8'h11, 16'h0000, 1, 2, 16'h0020, 0, 4'd5, 8'h11};
    v[7]  = '{0, 0, 0,  1, 8'h22, 16'h0000, 1, 1, 16'h0024, 0, 4'd2, 8'h22};
    v[8]  = '{0, 0, 0,  1, 8'h33, 16'h0000, 1, 0, 16'h0224, 0, 4'd9, 8'h33};
    v[9]  = '{0, 1, 5,  0, 8'h00, 16'h0224, 0, 0, 16'h0000, 0, 4'd9, 8'h33};
    v[10] = '{0, 1, 5,  0, 8'h00, 16'h0000, 1, 1, 16'h0000, 0, 4'd5, 8'h11};
    v[11] = '{0, 0, 0,  1, 8'h44, 16'h0000, 1, 0, 16'h0020, 0, 4'd5, 8'h44};
    v[12] = '{0, 1, 5,  0, 8'h00, 16'h0000, 0, 0, 16'h0020, 0, 4'd5, 8'h44};
    v[13] = '{0, 1, 5,  0, 8'h00, 16'h0020, 0, 0, 16'h0000, 0, 4'd5, 8'h44};
    v[14] = '{0, 1, 5,  0, 8'h00, 16'h0000, 1, 1, 16'h0000, 0, 4'd5, 8'h44};
    v[15] = '{0, 0, 0,  1, 8'h55, 16'h0000, 1, 0, 16'h0020, 0, 4'd5, 8'h55};
    v[16] = '{0, 0, 0,  0, 8'h00, 16'h0020, 1, 0, 16'h0000, 0, 4'd5, 8'h55};
    v[17] = '{0, 0, 0,  1, 8'h66, 16'h0000, 1, 0, 16'h0000, 1, 4'd5, 8'h55};
    v[18] = '{0, 1, 0,  1, 8'h99, 16'h0000, 1, 1, 16'h0000, 1, 4'd0, 8'h00};
    v[19] = '{0, 0, 0,  1, 8'h77, 16'h0000, 0, 0, 16'h0001, 1, 4'd0, 8'h77};
    v[20] = '{0, 0, 0,  0, 8'h00, 16'h0001, 0, 0, 16'h0000, 1, 4'd0, 8'h77};
    drive(1, 0, 0, 0, 8'h00, 16'h0000);
    #1;
    for (int i = 0; i < 21; i++) begin
      drive(v[i].rst, v[i].iv, v[i].ip, v[i].rdv, v[i].rb, v[i].pr);
      #1;
      chk($sformatf("v%0d issue_ready", i), dw'(issue_ready), dw'(v[i].er));
      tick();
      chk($sformatf("v%0d outstanding", i), dw'(outstanding), dw'(v[i].eo));
      chk($sformatf("v%0d port_valid", i), dw'(port_valid), dw'(v[i].epv));
      chk($sformatf("v%0d err_underflow", i), dw'(err_underflow), dw'(v[i].ee));
      chk($sformatf("v%0d slice%0d", i, v[i].cp), port_data[int'(v[i].cp)*dw +: dw], {32{v[i].cb}});
    end
    // Fill the tag FIFO, then show a same-cycle pop does not reopen issue_ready.
    drive(1, 0, 0, 0, 8'h00, 16'h0000);
    tick();
    for (int p = 0; p < 8; p++) begin
      drive(0, 1, 4'(p), 0, 8'h00, 16'h0000);
      #1;
      chk($sformatf("fill%0d issue_ready", p), dw'(issue_ready), dw'(1));
      tick();
    end
    chk("full outstanding", dw'(outstanding), dw'(8));
    drive(0, 1, 4'd8, 1, 8'hC3, 16'h0000);
    #1;
    chk("full ready with pop", dw'(issue_ready), dw'(0));
    tick();
    chk("after pop outstanding", dw'(outstanding), dw'(7));
    chk("after pop port_valid", dw'(port_valid), dw'(16'h0001));
    chk("after pop slice0", port_data[0 +: dw], {32{8'hC3}});
    drive(0, 1, 4'd8, 0, 8'h00, 16'h0000);
    #1;
    chk("ninth ready", dw'(issue_ready), dw'(1));
    tick();
    chk("ninth outstanding", dw'(outstanding), dw'(8));
    // Reset with three reads in flight and held data on port 1.
    drive(1, 0, 0, 0, 8'h00, 16'h0000);
    tick();
    drive(0, 1, 4'd1, 0, 8'h00, 16'h0000);
    tick();
    drive(0, 1, 4'd2, 1, 8'h5A, 16'h0000);
    tick();
    drive(0, 1, 4'd3, 0, 8'h00, 16'h0000);
    tick();
    drive(0, 1, 4'd4, 0, 8'h00, 16'h0000);
    tick();
    chk("pre-rst outstanding", dw'(outstanding), dw'(3));
    chk("pre-rst port_valid", dw'(port_valid), dw'(16'h0002));
    drive(1, 1, 4'd6, 0, 8'h00, 16'h0000);
    #1;
    chk("rst issue_ready", dw'(issue_ready), dw'(0));
    tick();
    chk("rst outstanding", dw'(outstanding), dw'(0));
    chk("rst port_valid", dw'(port_valid), dw'(0));
    chk("rst err", dw'(err_underflow), dw'(0));
    total++;
    if (port_data !== '0) begin
      bad++;
      $display("FAIL rst port_data: got nonzero want 0");
    end
    drive(0, 0, 0, 1, 8'hEE, 16'h0000);
    tick();
    chk("post-rst underflow", dw'(err_underflow), dw'(1));
    chk("post-rst port_valid", dw'(port_valid), dw'(0));
    chk("post-rst slice2", port_data[2*dw +: dw], '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/read_data_dispatcher.md
READ_DATA_DISPATCHER -- requirements
Module: read_data_dispatcher

Interface
REQ-001 Parameter num_of_ports, default 16, number of client read ports; port index is fixed 4 bits.
REQ-002 Parameter arbiter_data_width, default 256, width of one data word.
REQ-003 Parameter tag_depth, default 8, entries in the in-order tag FIFO; power of two, 2..16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 issue_valid  input  1  an SRAM read is being issued on behalf of issue_port.
REQ-007 issue_port  input  4  requesting client port index.
REQ-008 issue_ready  output  1  issue accepted this cycle when high together with issue_valid.
REQ-009 rd_data_valid  input  1  SRAM returns one read word this cycle, in issue order.
REQ-010 rd_data  input  arbiter_data_width  returned SRAM word.
REQ-011 port_data  output  arbiter_data_width*num_of_ports  packed per-port holding registers; port i occupies bits [(i+1)*arbiter_data_width-1 : i*arbiter_data_width].
REQ-012 port_valid  output  num_of_ports  holding register i contains undelivered data.
REQ-013 port_ready  input  num_of_ports  client i accepts its data.
REQ-014 outstanding  output  5  issued reads not yet returned (tag FIFO occupancy).
REQ-015 err_underflow  output  1  sticky: rd_data_valid arrived with no outstanding tag.

Function
REQ-016 Issue handshake: accepted when issue_valid && issue_ready; issue_ready = !fifo_full && !busy[issue_port] && !rst, combinational.
REQ-017 busy[i]: set on the clock edge that accepts an issue for port i; cleared on the edge after the cycle in which port_valid[i] && port_ready[i].
REQ-018 At most one read per port in flight or held; a port's holding register is therefore never overwritten.
REQ-019 On acceptance, issue_port is pushed to the tag FIFO tail; outstanding increments by 1.
REQ-020 On rd_data_valid with FIFO non-empty: pop head tag t; rd_data is written to holding register t and port_valid[t] is set on the same edge (1-cycle latency from rd_data_valid to port_valid); outstanding decrements by 1.
REQ-021 Simultaneous push and pop in one cycle: both performed, outstanding unchanged.
REQ-022 FIFO full (outstanding == tag_depth): issue_ready = 0 even if a pop occurs the same cycle.
REQ-023 rd_data_valid with FIFO empty (including the same cycle as the first push): no pop, no port update, data dropped, err_underflow set to 1 and held until reset; an issue in that cycle is still accepted normally.
REQ-024 Port delivery: port_valid[i] && port_ready[i] clears port_valid[i] next edge; port_data slice i retains its last value after delivery.
REQ-025 port_ready[i] while port_valid[i] = 0 has no effect.
REQ-026 Multiple ports may deliver in the same cycle independently.
REQ-027 Read and write pointers wrap modulo tag_depth.

Reset
REQ-028 While rst = 1 at a clock edge: FIFO pointers and outstanding = 0, busy = 0, port_valid = 0, port_data = 0, err_underflow = 0.
REQ-029 rst mid-operation discards all in-flight tags and held data; rd_data_valid arriving after rst releases is treated as underflow.
REQ-030 issue_ready = 0 during reset; first acceptance possible the cycle after rst deasserts.

Verification
REQ-031 Issue port 3, rd_data_valid next cycle with rd_data = 0xA5..A5 -> port_valid[3] = 1 one cycle later, slice 3 = 0xA5..A5, outstanding 1 -> 0; port_ready[3] = 1 -> port_valid[3] = 0 next cycle.
REQ-032 Issue ports 5,2,9 back-to-back, return words W0,W1,W2 -> slices 5,2,9 receive W0,W1,W2 respectively, in order.
REQ-033 Issue port 7, hold port_ready[7] = 0 after data arrives, retry issue port 7 -> issue_ready = 0 until the cycle after the port-7 handshake.
REQ-034 Issue 8 distinct ports without returns -> outstanding = 8, issue_ready = 0 for a 9th port; one return -> 9th accepted the cycle after.
REQ-035 rd_data_valid with outstanding = 0 -> err_underflow = 1, port_valid unchanged, stays 1 until rst.
REQ-036 Assert rst with 3 outstanding and port_valid[1] = 1 -> all outputs 0 next cycle, subsequent rd_data_valid sets err_underflow.
